regfile_exec_seq: RTL and testbench

- Sequencing execute stage that sits between the instruction source and the 8x16 register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the regfile read addresses, captures both operands, and computes the result (single-cycle ALU ops or a 16-cycle shift-add multiply).
- Writes the result back through the regfile write port (WR_data/WR_addr/WEn).

---
 rtl/regfile_exec_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_regfile_exec_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_exec_seq.sv
// Sequencing execute stage: reads two operands from the 8x16 regfile,
// runs a single-cycle ALU op or a 16-cycle shift-add multiply, writes back.
module regfile_exec_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] RA_addr,
    output logic [ADDR_W-1:0] RB_addr,
    input  logic [DATA_W-1:0] RA_data,
    input  logic [DATA_W-1:0] RB_data,
    output logic [DATA_W-1:0] WR_data,
    output logic [ADDR_W-1:0] WR_addr,
    output logic              WEn,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   r_q, r_d;
    logic                c_q, c_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [ADDR_W-1:0]   rb_q, rb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                wen_q, wen_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fz_q, fz_d;
    logic                fc_q, fc_d;

    logic [DATA_W-1:0]   res;
    logic                carry;
    logic [DATA_W:0]     sum;
    logic                legal;
    logic                finish;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fz_d    = fz_q;
        fc_d    = fc_q;
        res     = '0;
        carry   = 1'b0;
        sum     = '0;
        legal   = (op_q <= OP_LDI);
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    imm_d   = instr_imm;
                    ra_d    = instr_rs;
                    rb_d    = instr_rt;
                    ready_d = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = RA_data;
                b_d     = RB_data;
                r_d     = '0;
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                finish = 1'b1;
                unique case (op_q)
                    OP_ADD: begin
                        sum   = {1'b0, a_q} + {1'b0, b_q};
                        res   = sum[DATA_W-1:0];
                        carry = sum[DATA_W];
                    end
                    OP_SUB: begin
                        res   = a_q - b_q;
                        carry = (a_q < b_q);
                    end
                    OP_AND: res = a_q & b_q;
                    OP_OR:  res = a_q | b_q;
                    OP_XOR: res = a_q ^ b_q;
                    OP_SLL: res = a_q << b_q[3:0];
                    OP_SRL: res = a_q >> b_q[3:0];
                    OP_MUL: begin
                        // A shifts left, B shifts right; add A when B's LSB is set
                        res    = b_q[0] ? (r_q + a_q) : r_q;
                        a_d    = a_q << 1;
                        b_d    = b_q >> 1;
                        cnt_d  = cnt_q + 4'd1;
                        finish = (cnt_q == 4'd15);
                    end
                    OP_LDI: res = imm_q;
                    default: res = '0;
                endcase
                r_d = res;
                c_d = carry;
                if (finish) begin
                    state_d = S_WB;
                    done_d  = 1'b1;
                    err_d   = !legal;
                    wen_d   = legal;
                    if (legal) begin
                        waddr_d = rd_q;
                        wdata_d = res;
                    end
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (wen_q) begin
                    fz_d = (wdata_q == '0);
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        fc_d = c_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            ra_q    <= '0;
            rb_q    <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

    assign instr_ready = ready_q;
    assign RA_addr     = ra_q;
    assign RB_addr     = rb_q;
    assign WR_data     = wdata_q;
    assign WR_addr     = waddr_q;
    assign WEn         = wen_q;
    assign done        = done_q;
    assign err         = err_q;
    assign flag_z      = fz_q;
    assign flag_c      = fc_q;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// Directed bench for regfile_exec_seq with a behavioural 8x16 regfile
// attached to its read and write ports.
module tb_regfile_exec_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs;
    logic [2:0]  instr_rt;
    logic [15:0] instr_imm;
    logic [2:0]  RA_addr;
    logic [2:0]  RB_addr;
    logic [15:0] RA_data;
    logic [15:0] RB_data;
    logic [15:0] WR_data;
    logic [2:0]  WR_addr;
    logic        WEn;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_c;

    logic [15:0] rf [8];

    int n_checks = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    regfile_exec_seq #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_rt    (instr_rt),
        .instr_imm   (instr_imm),
        .RA_addr     (RA_addr),
        .RB_addr     (RB_addr),
        .RA_data     (RA_data),
        .RB_data     (RB_data),
        .WR_data     (WR_data),
        .WR_addr     (WR_addr),
        .WEn         (WEn),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign RA_data = rf[RA_addr];
    assign RB_data = rf[RB_addr];

    always @(posedge clk) begin
        if (WEn) rf[WR_addr] <= WR_data;
    end

    always @(negedge clk) begin
        if (WEn) wen_cnt++;
        if (done) done_cnt++;
        if (instr_valid && instr_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction and waits for its done pulse; starts and ends
    // 1 time unit after a rising edge.
    task automatic exec_instr(input logic [3:0] op, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt,
                              input logic [15:0] imm, output int lat,
                              output logic [15:0] wd, output logic [2:0] wa,
                              output logic we, output logic er,
                              output int bad_rdy);
        int w;
        lat = -1;
        wd = '0;
        wa = '0;
        we = 1'b0;
        er = 1'b0;
        bad_rdy = 0;
        instr_op = op;
        instr_rd = rd;
        instr_rs = rs;
        instr_rt = rt;
        instr_imm = imm;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                wd = WR_data;
                wa = WR_addr;
                we = WEn;
                er = err;
                break;
            end
            if (instr_ready) bad_rdy++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [15:0] imm,
                         input int exp_lat, input logic exp_we,
                         input logic exp_err, input logic [15:0] exp_wd);
        int lat;
        int bad;
        logic [15:0] wd;
        logic [2:0] wa;
        logic we;
        logic er;
        exec_instr(op, rd, rs, rt, imm, lat, wd, wa, we, er, bad);
        check($sformatf("%s_lat", tag), lat, exp_lat);
        check($sformatf("%s_wen", tag), {31'd0, we}, {31'd0, exp_we});
        check($sformatf("%s_err", tag), {31'd0, er}, {31'd0, exp_err});
        check($sformatf("%s_busy_rdy", tag), bad, 0);
        if (exp_we) begin
            check($sformatf("%s_waddr", tag), {29'd0, wa}, {29'd0, rd});
            check($sformatf("%s_wdata", tag), {16'd0, wd}, {16'd0, exp_wd});
        end
    endtask

    initial begin
        int w0;
        int d0;
        int a0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = '0;
        instr_rd = '0;
        instr_rs = '0;
        instr_rt = '0;
        instr_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_wen", {31'd0, WEn}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fz", {31'd0, flag_z}, 32'd0);
        check("rst_fc", {31'd0, flag_c}, 32'd0);

        do_op("ldi0", 4'd8, 3'd0, 3'd0, 3'd0, 16'habcd, 3, 1, 0, 16'habcd);
        do_op("ldi1", 4'd8, 3'd1, 3'd0, 3'd0, 16'h0123, 3, 1, 0, 16'h0123);
        do_op("add", 4'd0, 3'd2, 3'd0, 3'd1, 16'h0, 3, 1, 0, 16'hacf0);
        check("add_fc", {31'd0, flag_c}, 32'd0);
        check("add_fz", {31'd0, flag_z}, 32'd0);
        do_op("sub", 4'd1, 3'd3, 3'd1, 3'd0, 16'h0, 3, 1, 0, 16'h5556);
        check("sub_fc", {31'd0, flag_c}, 32'd1);

        do_op("ldi4", 4'd8, 3'd4, 3'd0, 3'd0, 16'h0012, 3, 1, 0, 16'h0012);
        do_op("ldi5", 4'd8, 3'd5, 3'd0, 3'd0, 16'h0034, 3, 1, 0, 16'h0034);
        do_op("mul", 4'd7, 3'd6, 3'd4, 3'd5, 16'h0, 18, 1, 0, 16'h03a8);
        check("mul_fc_held", {31'd0, flag_c}, 32'd1);
        do_op("ldi6", 4'd8, 3'd6, 3'd0, 3'd0, 16'h0014, 3, 1, 0, 16'h0014);
        do_op("sll", 4'd5, 3'd7, 3'd0, 3'd6, 16'h0, 3, 1, 0, 16'hbcd0);
        do_op("srl", 4'd6, 3'd7, 3'd0, 3'd6, 16'h0, 3, 1, 0, 16'h0abc);

        do_op("xor", 4'd4, 3'd0, 3'd0, 3'd0, 16'h0, 3, 1, 0, 16'h0000);
        check("xor_fz", {31'd0, flag_z}, 32'd1);
        check("xor_fc_held", {31'd0, flag_c}, 32'd1);
        check("xor_r0", {16'd0, rf[0]}, 32'h0);

        // MUL aborted by reset five cycles into EXEC
        instr_op = 4'd7;
        instr_rd = 3'd6;
        instr_rs = 3'd4;
        instr_rt = 3'd5;
        instr_valid = 1'b1;
        w0 = wen_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        check("abort_wen", {31'd0, WEn}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_fz", {31'd0, flag_z}, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_wen_cnt", wen_cnt - w0, 0);
        check("abort_done_cnt", done_cnt - d0, 0);
        check("abort_r6", {16'd0, rf[6]}, 32'h0014);

        do_op("sub2", 4'd1, 3'd3, 3'd0, 3'd1, 16'h0, 3, 1, 0, 16'hfedd);
        check("sub2_fc", {31'd0, flag_c}, 32'd1);
        check("sub2_fz", {31'd0, flag_z}, 32'd0);
        do_op("ldiz", 4'd8, 3'd5, 3'd0, 3'd0, 16'h0000, 3, 1, 0, 16'h0000);
        check("ldiz_fz", {31'd0, flag_z}, 32'd1);
        w0 = wen_cnt;
        do_op("ill", 4'hc, 3'd1, 3'd2, 3'd3, 16'h0, 3, 0, 1, 16'h0);
        check("ill_wen_cnt", wen_cnt - w0, 0);
        check("ill_fz", {31'd0, flag_z}, 32'd1);
        check("ill_fc", {31'd0, flag_c}, 32'd1);
        check("ill_r1", {16'd0, rf[1]}, 32'h0123);

        // instr_valid held high across three back-to-back LDIs
        a0 = acc_cnt;
        d0 = done_cnt;
        w0 = wen_cnt;
        instr_op = 4'd8;
        instr_rd = 3'd2;
        instr_imm = 16'h0077;
        instr_valid = 1'b1;
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hold_accepts", acc_cnt - a0, 3);
        check("hold_dones", done_cnt - d0, 3);
        check("hold_wens", wen_cnt - w0, 3);
        check("hold_r2", {16'd0, rf[2]}, 32'h0077);
        check("hold_fz", {31'd0, flag_z}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
